// File: rtl/aes_enc_scheduler.sv
// rtl/aes_enc_scheduler.sv - shares one AES-128 encrypt datapath between requesters A and B
// Round-robin arbiter with held core inputs, settle countdown and a tagged response register.
module aes_enc_scheduler #(
  parameter int LATENCY   = 50,
  parameter int KEY_EXTRA = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_plain,
  input  logic [127:0] a_key,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [127:0] b_plain,
  input  logic [127:0] b_key,
  output logic [127:0] core_plain,
  output logic [127:0] core_key,
  input  logic [127:0] core_cipher,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_cipher,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SHORT_M1 = 8'(LATENCY - 1);
  localparam logic [7:0] LONG_M1  = 8'(LATENCY + KEY_EXTRA - 1);

  state_t       state_q, state_d;
  logic [7:0]   counter_q, counter_d;
  logic [127:0] core_plain_q, core_plain_d;
  logic [127:0] core_key_q, core_key_d;
  logic         key_known_q, key_known_d;
  logic         last_served_q, last_served_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [127:0] rsp_cipher_q, rsp_cipher_d;

  logic         idle;
  logic         grant_b;
  logic         accept;
  logic [127:0] sel_plain;
  logic [127:0] sel_key;
  logic         key_change;

  // On a tie, the requester that was not served last wins (last_served: 0 = A, 1 = B).
  assign idle       = (state_q == S_IDLE);
  assign grant_b    = b_valid && (!a_valid || !last_served_q);
  assign a_ready    = idle && a_valid && !grant_b;
  assign b_ready    = idle && grant_b;
  assign accept     = idle && (a_valid || b_valid);
  assign sel_plain  = grant_b ? b_plain : a_plain;
  assign sel_key    = grant_b ? b_key : a_key;
  assign key_change = !key_known_q || (sel_key != core_key_q);

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    core_plain_d  = core_plain_q;
    core_key_d    = core_key_q;
    key_known_d   = key_known_q;
    last_served_d = last_served_q;
    id_d          = id_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_cipher_d  = rsp_cipher_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          core_plain_d = sel_plain;
          core_key_d   = sel_key;
          id_d         = grant_b;
          counter_d    = key_change ? LONG_M1 : SHORT_M1;
          key_known_d  = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (counter_q != 8'd0) begin
          counter_d = counter_q - 8'd1;
        end else begin
          rsp_cipher_d = core_cipher;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          last_served_d = id_q;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      counter_q     <= 8'd0;
      core_plain_q  <= '0;
      core_key_q    <= '0;
      key_known_q   <= 1'b0;
      last_served_q <= 1'b1;
      id_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_cipher_q  <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      core_plain_q  <= core_plain_d;
      core_key_q    <= core_key_d;
      key_known_q   <= key_known_d;
      last_served_q <= last_served_d;
      id_q          <= id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_cipher_q  <= rsp_cipher_d;
    end
  end

  assign core_plain = core_plain_q;
  assign core_key   = core_key_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_cipher = rsp_cipher_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// tb/tb_aes_enc_scheduler.sv - directed self-checking bench for aes_enc_scheduler
// The core stand-in returns garbage until its inputs have been stable for 50 (70 on key change) cycles.
module tb_aes_enc_scheduler;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT3 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] PT4 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT5 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] PT6 = 128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c;
  localparam logic [127:0] PT7 = 128'hdeadbeefcafef00d0badf00d12345678;
  localparam logic [127:0] GARBAGE = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         a_ready, b_ready;
  logic [127:0] a_plain = '0, a_key = '0, b_plain = '0, b_key = '0;
  logic [127:0] core_plain, core_key, core_cipher;
  logic         rsp_valid, rsp_id, busy;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_cipher;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_enc_scheduler #(.LATENCY(50), .KEY_EXTRA(20)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_plain(a_plain), .a_key(a_key),
    .b_valid(b_valid), .b_ready(b_ready), .b_plain(b_plain), .b_key(b_key),
    .core_plain(core_plain), .core_key(core_key), .core_cipher(core_cipher),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cipher(rsp_cipher), .busy(busy)
  );

  // FIPS-197 vector for PT1/K1; any other pair maps to a cheap keyed mix.
  function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
    if (p == PT1 && k == K1) return CT1;
    return p ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  logic [127:0] m_last_p = '0, m_last_k = '0;
  int m_age = 0, m_need = 0;

  always @(negedge clk) begin
    if (core_plain !== m_last_p || core_key !== m_last_k) begin
      m_need   <= (core_key !== m_last_k) ? 70 : 50;
      m_age    <= 0;
      m_last_p <= core_plain;
      m_last_k <= core_key;
    end else if (m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end

  always_comb core_cipher = (m_age >= m_need - 1) ? aes_ref(core_plain, core_key) : GARBAGE;

  // Drives one job and returns: accepted, ready still high after accept, edges from accept to capture.
  task automatic run_job(input logic who, input logic [127:0] p, input logic [127:0] k,
                         output logic acc_ok, output logic rdy_after, output int lat);
    @(negedge clk);
    if (who) begin b_valid = 1'b1; b_plain = p; b_key = k; end
    else     begin a_valid = 1'b1; a_plain = p; a_key = k; end
    acc_ok = 1'b0;
    rdy_after = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (who ? b_ready : a_ready) begin acc_ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc_ok) begin
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rdy_after = a_ready | b_ready;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin lat = n; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %0b want 0", rsp_id); end
    n_tests++; if (rsp_cipher !== '0) begin n_fail++; $display("FAIL reset_rsp_cipher got %h want 0", rsp_cipher); end
    n_tests++; if (core_plain !== '0) begin n_fail++; $display("FAIL reset_core_plain got %h want 0", core_plain); end
    n_tests++; if (core_key !== '0) begin n_fail++; $display("FAIL reset_core_key got %h want 0", core_key); end
  endtask

  task automatic test_single_a;
    logic acc, rdy; int lat;
    rsp_ready = 1'b0;
    run_job(1'b0, PT1, K1, acc, rdy, lat);
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept got %0b want 1", acc); end
    n_tests++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL single_ready_one_cycle got %0b want 0", rdy); end
    n_tests++; if (lat != 70) begin n_fail++; $display("FAIL single_latency got %0d want 70", lat); end
    n_tests++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_id got %0b want 0", rsp_id); end
    n_tests++; if (rsp_cipher !== CT1) begin n_fail++; $display("FAIL single_cipher got %h want %h", rsp_cipher, CT1); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_drop got %0b want 0", rsp_valid); end
    n_tests++; if (rsp_cipher !== CT1) begin n_fail++; $display("FAIL single_cipher_kept got %h want %h", rsp_cipher, CT1); end
  endtask

  task automatic test_same_key_b;
    logic acc, rdy; int lat;
    rsp_ready = 1'b1;
    run_job(1'b1, PT2, K1, acc, rdy, lat);
    n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL samekey_accept got %0b want 1", acc); end
    n_tests++; if (lat != 50) begin n_fail++; $display("FAIL samekey_latency got %0d want 50", lat); end
    n_tests++; if (rsp_id !== 1'b1) begin n_fail++; $display("FAIL samekey_id got %0b want 1", rsp_id); end
    n_tests++; if (rsp_cipher !== aes_ref(PT2, K1)) begin n_fail++; $display("FAIL samekey_cipher got %h want %h", rsp_cipher, aes_ref(PT2, K1)); end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL samekey_back_idle got %0b want 0", busy); end
  endtask

  task automatic test_alternation;
    logic gid[4]; int gc[4]; int ng; int overlap;
    logic want_id[4];
    want_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    ng = 0; overlap = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    a_plain = PT4; a_key = K1; b_plain = PT5; b_key = K1;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (busy && (a_ready || b_ready)) overlap++;
      if (a_ready && b_ready) overlap++;
      if (a_ready || b_ready) begin
        gid[ng] = b_ready; gc[ng] = c; ng++;
        if (ng == 4) break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    n_tests++; if (ng != 4) begin n_fail++; $display("FAIL alt_grant_count got %0d want 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_tests++; if (gid[i] !== want_id[i]) begin n_fail++; $display("FAIL alt_grant_%0d got %0b want %0b", i, gid[i], want_id[i]); end
    end
    for (int i = 1; i < ng; i++) begin
      n_tests++; if (gc[i] - gc[i-1] != 52) begin n_fail++; $display("FAIL alt_spacing_%0d got %0d want 52", i, gc[i] - gc[i-1]); end
    end
    n_tests++; if (overlap != 0) begin n_fail++; $display("FAIL alt_ready_while_busy got %0d want 0", overlap); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL alt_drain got busy %0b want 0", busy); end
  endtask

  task automatic test_hold_done;
    logic acc, rdy; int lat; int unstable; int stray;
    logic [127:0] saved;
    unstable = 0; stray = 0;
    rsp_ready = 1'b0;
    run_job(1'b0, PT3, K1, acc, rdy, lat);
    n_tests++; if (lat != 50) begin n_fail++; $display("FAIL hold_latency got %0d want 50", lat); end
    saved = rsp_cipher;
    b_plain = PT2; b_key = K1; b_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_cipher !== saved) unstable++;
      if (a_ready || b_ready || !busy) stray++;
    end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL hold_stable got %0d changes want 0", unstable); end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL hold_no_accept got %0d want 0", stray); end
    n_tests++; if (saved !== aes_ref(PT3, K1)) begin n_fail++; $display("FAIL hold_cipher got %h want %h", saved, aes_ref(PT3, K1)); end
    b_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_complete got rsp_valid %0b want 0", rsp_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_idle got busy %0b want 0", busy); end
  endtask

  task automatic test_key_change;
    logic acc, rdy; int lat;
    rsp_ready = 1'b1;
    run_job(1'b0, PT4, K2, acc, rdy, lat);
    n_tests++; if (lat != 70) begin n_fail++; $display("FAIL keychg_new_latency got %0d want 70", lat); end
    n_tests++; if (rsp_cipher !== aes_ref(PT4, K2)) begin n_fail++; $display("FAIL keychg_new_cipher got %h want %h", rsp_cipher, aes_ref(PT4, K2)); end
    run_job(1'b0, PT5, K1, acc, rdy, lat);
    n_tests++; if (lat != 70) begin n_fail++; $display("FAIL keychg_back_latency got %0d want 70", lat); end
    n_tests++; if (rsp_cipher !== aes_ref(PT5, K1)) begin n_fail++; $display("FAIL keychg_back_cipher got %h want %h", rsp_cipher, aes_ref(PT5, K1)); end
    run_job(1'b0, PT6, K1, acc, rdy, lat);
    n_tests++; if (lat != 50) begin n_fail++; $display("FAIL keychg_same_latency got %0d want 50", lat); end
    n_tests++; if (rsp_cipher !== aes_ref(PT6, K1)) begin n_fail++; $display("FAIL keychg_same_cipher got %h want %h", rsp_cipher, aes_ref(PT6, K1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait;
    logic acc, rdy; int lat;
    logic seen_ready;
    rsp_ready = 1'b1;
    @(negedge clk);
    a_plain = PT7; a_key = K1; a_valid = 1'b1;
    #1 seen_ready = a_ready;
    n_tests++; if (seen_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept got %0b want 1", seen_ready); end
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (23) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rsp_valid got %0b want 0", rsp_valid); end
    n_tests++; if (core_key !== '0) begin n_fail++; $display("FAIL rstmid_core_key got %h want 0", core_key); end
    run_job(1'b0, PT7, K1, acc, rdy, lat);
    n_tests++; if (lat != 70) begin n_fail++; $display("FAIL rstmid_next_latency got %0d want 70", lat); end
    n_tests++; if (rsp_cipher !== aes_ref(PT7, K1)) begin n_fail++; $display("FAIL rstmid_next_cipher got %h want %h", rsp_cipher, aes_ref(PT7, K1)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_same_key_b();
    test_alternation();
    test_hold_done();
    test_key_change();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests, want completion", n_tests);
    $fatal(1);
  end

endmodule
